// File: rtl/data_demod_rx.sv
// Symbol-pair demodulator: rebuilds bytes from {marker, nibble} symbols and
// buffers them in a small circular FIFO drained with rd_en / data_valid.
module data_demod_rx #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        dmod,
  input  logic              mod_en,
  input  logic              rd_en,
  output logic [7:0]        data_o,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              sync_err,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_HI, S_LO} state_t;

  state_t            state, state_nxt;
  logic [3:0]        hi_nib, hi_nib_nxt;
  logic              push;
  logic [7:0]        push_byte;
  logic              serr_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              pop, push_ok;

  // ---------------- framing FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_HI;
      hi_nib <= '0;
    end else begin
      state  <= state_nxt;
      hi_nib <= hi_nib_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hi_nib_nxt = hi_nib;
    push       = 1'b0;
    push_byte  = {hi_nib, dmod[3:0]};
    serr_nxt   = 1'b0;
    if (mod_en) begin
      case (state)
        S_HI: begin
          if (dmod[4]) begin
            hi_nib_nxt = dmod[3:0];
            state_nxt  = S_LO;
          end else begin
            serr_nxt = 1'b1;
          end
        end
        S_LO: begin
          if (dmod[4]) begin
            // orphaned high nibble: the new first symbol restarts the byte
            serr_nxt   = 1'b1;
            hi_nib_nxt = dmod[3:0];
          end else begin
            push      = 1'b1;
            state_nxt = S_HI;
          end
        end
        default: state_nxt = S_HI;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  assign pop     = rd_en && (cnt != '0);
  // a same-cycle pop frees the slot the push is about to use
  assign push_ok = push && ((cnt < DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      data_o     <= 8'h00;
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync_err   <= serr_nxt;
      data_valid <= pop;
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        data_o <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);

endmodule

// File: tb/tb_data_demod_rx.sv
// Self-checking bench for data_demod_rx: vector table plus scoreboard queue
// of expected bytes, compared as each pop produces data_valid.
module tb_data_demod_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] dmod;
  logic       mod_en;
  logic       rd_en;
  logic [7:0] data_o;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       sync_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  data_demod_rx #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .dmod(dmod), .mod_en(mod_en), .rd_en(rd_en),
    .data_o(data_o), .data_valid(data_valid), .empty(empty), .full(full),
    .count(count), .sync_err(sync_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] s0;
    logic [4:0] s1;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] s, input logic exp_serr);
    dmod   = s;
    mod_en = 1'b1;
    tick();
    mod_en = 1'b0;
    chk("sync_err", sync_err, exp_serr);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send({1'b1, b[7:4]}, 1'b0);
    send({1'b0, b[3:0]}, 1'b0);
  endtask

  task automatic pop_chk(input string name);
    logic [7:0] e;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, ".valid"}, data_valid, 1'b1);
      chk({name, ".data"}, data_o, e);
    end else begin
      chk({name, ".novalid"}, data_valid, 1'b0);
    end
  endtask

  initial begin
    vec_t vecs[4];
    logic [7:0] held;
    vecs[0] = '{5'h1A, 5'h05, 0, 8'hA5};
    vecs[1] = '{5'h13, 5'h0C, 5, 8'h3C};
    vecs[2] = '{5'h1F, 5'h0F, 0, 8'hFF};
    vecs[3] = '{5'h10, 5'h01, 2, 8'h01};

    reset_n = 1'b0; dmod = '0; mod_en = 1'b0; rd_en = 1'b0;
    tick();
    chk("rst.data_o", data_o, 8'h00);
    chk("rst.valid", data_valid, 1'b0);
    chk("rst.empty", empty, 1'b1);
    chk("rst.full", full, 1'b0);
    chk("rst.count", count, 0);
    chk("rst.serr", sync_err, 1'b0);
    chk("rst.ovf", overflow, 1'b0);
    reset_n = 1'b1;
    tick();

    // table: single byte with optional gap between symbols, popped immediately
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].s0, 1'b0);
      repeat (vecs[i].gap) tick();
      send(vecs[i].s1, 1'b0);
      sb.push_back(vecs[i].exp);
      chk("vec.count", count, 1);
      chk("vec.empty", empty, 1'b0);
      pop_chk("vec.pop");
      chk("vec.empty_after", empty, 1'b1);
      tick();
      chk("vec.pulse_once", data_valid, 1'b0);
    end

    // two bytes queued back-to-back, drained in order
    send(5'h13, 1'b0); repeat (5) tick(); send(5'h0C, 1'b0);
    send(5'h1F, 1'b0); send(5'h0F, 1'b0);
    sb.push_back(8'h3C); sb.push_back(8'hFF);
    chk("gap2.count", count, 2);
    pop_chk("gap2.pop0");
    pop_chk("gap2.pop1");

    // framing errors: stray low symbol, then orphaned high nibble
    send(5'h07, 1'b1);
    send(5'h12, 1'b0);
    send(5'h14, 1'b1);
    send(5'h09, 1'b0);
    sb.push_back(8'h49);
    chk("frm.count", count, 1);
    pop_chk("frm.pop");

    // fill to full, overflow on the 17th byte
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      if (i < 16) sb.push_back(8'(i));
      if (i == 15) begin
        chk("fill.full", full, 1'b1);
        chk("fill.ovf_clear", overflow, 1'b0);
      end
    end
    chk("ovf.set", overflow, 1'b1);
    chk("ovf.count", count, 16);
    for (int i = 0; i < 16; i++) pop_chk("drain");
    chk("drain.empty", empty, 1'b1);
    chk("ovf.sticky", overflow, 1'b1);

    // simultaneous push and pop while full
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h20 + i));
      sb.push_back(8'(8'h20 + i));
    end
    chk("sim.full", full, 1'b1);
    send(5'h13, 1'b0);
    dmod = 5'h05; mod_en = 1'b1; rd_en = 1'b1;
    tick();
    mod_en = 1'b0; rd_en = 1'b0;
    chk("sim.valid", data_valid, 1'b1);
    chk("sim.data", data_o, sb.pop_front());
    sb.push_back(8'h35);
    chk("sim.count", count, 16);
    chk("sim.ovf", overflow, 1'b1);
    for (int i = 0; i < 16; i++) pop_chk("sim.drain");
    held = 8'h35;
    pop_chk("empty.rd");
    chk("empty.hold", data_o, held);

    // reset in the middle of a byte with data buffered
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("rst2.pre", count, 3);
    send(5'h1E, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst2.count", count, 0);
    chk("rst2.empty", empty, 1'b1);
    chk("rst2.full", full, 1'b0);
    chk("rst2.data_o", data_o, 8'h00);
    chk("rst2.valid", data_valid, 1'b0);
    chk("rst2.ovf", overflow, 1'b0);
    chk("rst2.serr", sync_err, 1'b0);
    send(5'h04, 1'b1);
    chk("rst2.nostore", count, 0);
    pop_chk("rst2.rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_demod_rx.md
# data_demod_rx

Receive-side counterpart of the modulation path. It takes the 5-bit symbol stream `dmod`/`mod_en` produced by the modulator and reassembles bytes from symbol pairs. It detects framing errors and buffers recovered bytes in an internal FIFO, which a downstream consumer drains with an `rd_en`/`data_valid` handshake. It sits between the channel/loopback point and the byte-level consumer.

## Interface
- `DEPTH`, 16, FIFO depth in bytes; power of two, at least 2
- `ADDR_W`, 4, log2(`DEPTH`)

- `clk`  input  1  single clock; all logic rising-edge
- `reset_n`  input  1  reset, synchronous, active-low
- `dmod`  input  5  symbol; `[4]` = first-symbol marker, `[3:0]` = nibble
- `mod_en`  input  1  symbol valid; one symbol per cycle while high
- `rd_en`  input  1  pop request from consumer
- `data_o`  output  8  popped byte (registered)
- `data_valid`  output  1  one-cycle pulse: `data_o` updated this cycle
- `empty`  output  1  FIFO holds 0 bytes
- `full`  output  1  FIFO holds `DEPTH` bytes
- `count`  output  `ADDR_W`+1  bytes currently stored
- `sync_err`  output  1  one-cycle pulse on a framing error
- `overflow`  output  1  sticky; set when a completed byte is dropped because the FIFO is full

## Operation
- Symbol framing:
  - Each byte is two valid symbols, high nibble first.
  - First symbol carries `dmod[4]`=1; second symbol carries `dmod[4]`=0.
  - Gaps (`mod_en`=0) are allowed anywhere, of any length, with no timeout.
- FSM states:
  - `S_HI`: waiting for a first symbol.
  - `S_LO`: high nibble latched, waiting for the second symbol.
- Transitions, evaluated only when `mod_en`=1; otherwise state and latch hold:
  - `S_HI`, `dmod[4]`=1: latch `dmod[3:0]` as high nibble, go to `S_LO`.
  - `S_HI`, `dmod[4]`=0: stray symbol; discard it, pulse `sync_err`, stay in `S_HI`.
  - `S_LO`, `dmod[4]`=0: byte = {high nibble, `dmod[3:0]`}; issue a push; go to `S_HI`.
  - `S_LO`, `dmod[4]`=1: orphaned high nibble; pulse `sync_err`, latch the new nibble, stay in `S_LO`.
- FIFO:
  - Circular buffer with `ADDR_W`-bit read and write pointers. Pointers wrap modulo `DEPTH`.
  - `count` is tracked separately, range 0..`DEPTH`.
  - `empty` = (`count`==0); `full` = (`count`==`DEPTH`).
- Push rules:
  - A push is accepted if `count`<`DEPTH`, or if a pop is accepted in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- Pop rules:
  - A pop is accepted when `rd_en`=1 and `empty`=0, with `empty` evaluated before any same-cycle push.
  - `rd_en` while empty is ignored: no pulse, `data_o` holds.
- Simultaneous push and pop: both are performed and `count` is unchanged.
- Reset (`reset_n`=0 at a clock edge):
  - FSM goes to `S_HI`; pointers and `count` go to 0; any latched high nibble and all buffered bytes are discarded.
  - `data_o`=0x00, `data_valid`=0, `empty`=1, `full`=0, `count`=0, `sync_err`=0, `overflow`=0.
  - Reset mid-byte or mid-pop fully aborts the operation; no partial output appears after reset.

## Timing
- Second symbol sampled at edge N: the byte is written at edge N. After that edge, `count` reflects the write and `empty`=0.
- `rd_en` sampled at edge M with a pop accepted: after edge M, `data_o` = head byte and `data_valid`=1 for exactly one cycle.
- Minimum latency from the second symbol to the byte on `data_o` is 2 edges: symbol at N, `rd_en` at N+1, data visible after N+1.
- `sync_err` is asserted for the single cycle after the offending symbol's edge.
- Sustained input rate: one byte per 2 cycles. The consumer may pop every cycle.
- All outputs are registered, except that `empty`, `full` and `count` are decoded from registered state.

## Test plan
- Basic decode:
  - Stimulus: after reset, send symbols 0x1A, 0x05, then pulse `rd_en`.
  - Response: `count` goes 0→1; `data_o`=0xA5 with a single `data_valid` pulse; `empty`=1 afterwards.
- Gaps:
  - Stimulus: symbols 0x13, idle 5 cycles, 0x0C; then 0x1F, 0x0F back-to-back; pop twice.
  - Response: bytes 0x3C then 0xFF in order; no `sync_err`.
- Framing errors:
  - Stimulus: 0x07 (stray), 0x12, 0x14 (orphans 2), 0x09.
  - Response: two `sync_err` pulses; exactly one byte, 0x49, stored.
- Full and overflow:
  - Stimulus: push 17 bytes 0x00..0x10 with no reads.
  - Response: `full`=1 after the 16th; 0x10 dropped; `overflow`=1 and stays set.
  - Stimulus: then pop 16.
  - Response: 0x00..0x0F in order; `empty`=1.
- Simultaneous push and pop at full:
  - Stimulus: with `count`=16, complete a byte and assert `rd_en` in the same cycle.
  - Response: byte accepted; `count` stays 16; `overflow` unchanged.
  - Stimulus: `rd_en` while empty.
  - Response: no `data_valid` pulse.
- Reset mid-operation:
  - Stimulus: store 3 bytes, send a first symbol, assert `reset_n`=0 for 1 cycle, then send 0x04.
  - Response: `count`=0; all outputs at reset values; 0x04 produces `sync_err`; nothing stored.
